// File: rtl/carrier_track_loop.sv
// carrier_track_loop: carrier tracking PI loop with sweep, lock detector and acquire/track gain scheduling
module carrier_track_loop #(
  parameter int ERR_W = 8,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync,
  input  logic                    errorEn,
  input  logic [ERR_W-1:0]        error,
  input  logic                    invertError,
  input  logic                    zeroError,
  input  logic                    sweepEnable,
  input  logic                    clearAccum,
  input  logic [4:0]              acqLeadExp,
  input  logic [4:0]              acqLagExp,
  input  logic [4:0]              trkLeadExp,
  input  logic [4:0]              trkLagExp,
  input  logic [OUT_W-1:0]        limit,
  input  logic [OUT_W-1:0]        sweepRate,
  input  logic [ERR_W-2:0]        syncThreshold,
  input  logic [CNT_W-2:0]        lockCount,
  output logic [ERR_W-1:0]        loopError,
  output logic [OUT_W-1:0]        carrierFreqOffset,
  output logic [OUT_W-1:0]        carrierLeadFreq,
  output logic                    carrierFreqEn,
  output logic                    carrierLock,
  output logic signed [CNT_W-1:0] lockCounter,
  output logic [1:0]              loopState
);
  localparam int MAX_SH = ACC_W - ERR_W;
  localparam int ALIGN = ACC_W - OUT_W;
  localparam int WW = ACC_W + 2;
  localparam logic [ERR_W-1:0] MIN_ERR = {1'b1, {(ERR_W-1){1'b0}}};
  typedef enum logic [1:0] {SWEEP = 2'b00, ACQUIRE = 2'b01, TRACK = 2'b10} state_t;
  state_t state, stateNext;
  logic [OUT_W-1:0] lead;
  logic signed [ACC_W-1:0] lagAccum, errExt, leadTerm, lagTerm;
  logic signed [WW-1:0] limWide, stepWide, accWide, trkSum, sweepSum, accNext;
  logic signed [CNT_W-1:0] posCnt, negCnt, cntInc, cntDec;
  logic [ERR_W-1:0] errAbs, adjErr;
  logic valid, inTh, lockHit, unlockHit, lockEvt, unlockEvt, reachNeg, sweepHit, sweepDown;
  function automatic int clampSh(input logic [4:0] e);
    return (int'(e) > MAX_SH) ? MAX_SH : int'(e);
  endfunction
  assign valid = sync & errorEn;
  assign errAbs = error[ERR_W-1] ? -error : error;
  assign inTh = errAbs <= {1'b0, syncThreshold};
  // the most negative error has no positive twin, so inversion saturates it
  assign adjErr = (zeroError || state == SWEEP) ? '0 :
                  !invertError ? error : (error == MIN_ERR) ? ~MIN_ERR : -error;
  assign errExt = ACC_W'($signed(loopError));
  assign leadTerm = errExt <<< clampSh(state == TRACK ? trkLeadExp : acqLeadExp);
  assign lagTerm = errExt <<< clampSh(state == TRACK ? trkLagExp : acqLagExp);
  // two guard bits keep the sum and the +/-limit bounds free of overflow
  assign limWide = WW'(limit) <<< ALIGN;
  assign stepWide = WW'(sweepRate) <<< ALIGN;
  assign accWide = WW'(lagAccum);
  assign trkSum = accWide + WW'(lagTerm);
  assign sweepSum = sweepDown ? accWide - stepWide : accWide + stepWide;
  assign sweepHit = sweepDown ? (sweepSum <= -limWide) : (sweepSum >= limWide);
  assign accNext = (state == SWEEP) ? (sweepHit ? (sweepDown ? -limWide : limWide) : sweepSum) :
                   (trkSum > limWide) ? limWide : (trkSum < -limWide) ? -limWide : trkSum;
  assign posCnt = signed'({1'b0, lockCount});
  assign negCnt = -posCnt;
  assign cntInc = lockCounter + CNT_W'(1);
  assign cntDec = lockCounter - CNT_W'(1);
  assign lockHit = lockCounter == posCnt;
  assign unlockHit = lockCounter == negCnt;
  assign lockEvt = valid & inTh & lockHit;
  assign unlockEvt = valid & ~inTh & unlockHit;
  // the counter has reached the negative dwell either already or on this decrement
  assign reachNeg = valid & ~inTh & (unlockHit | (cntDec == negCnt));
  always_comb begin
    stateNext = state;
    if (state == SWEEP)
      stateNext = (!sweepEnable || (valid && inTh)) ? ACQUIRE : SWEEP;
    else if (state == ACQUIRE)
      stateNext = lockEvt ? TRACK : (sweepEnable && reachNeg) ? SWEEP : ACQUIRE;
    else if (state == TRACK)
      stateNext = !unlockEvt ? TRACK : sweepEnable ? SWEEP : ACQUIRE;
    else
      stateNext = sweepEnable ? SWEEP : ACQUIRE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= sweepEnable ? SWEEP : ACQUIRE;
      loopError <= '0;
      lead <= '0;
      lagAccum <= '0;
      lockCounter <= '0;
      carrierLock <= 1'b0;
      carrierFreqEn <= 1'b0;
      sweepDown <= 1'b0;
    end else begin
      state <= stateNext;
      carrierFreqEn <= valid;
      if (valid) begin
        loopError <= adjErr;
        lead <= OUT_W'(leadTerm >>> ALIGN);
        lockCounter <= inTh ? (lockHit ? '0 : cntInc) : (unlockHit ? '0 : cntDec);
        carrierLock <= inTh ? (lockHit | carrierLock) : (carrierLock & ~unlockHit);
      end
      if (clearAccum) begin
        lagAccum <= '0;
        sweepDown <= 1'b0;
      end else if (valid) begin
        lagAccum <= ACC_W'(accNext);
        sweepDown <= sweepDown ^ (state == SWEEP && sweepHit);
      end
    end
  end
  assign carrierFreqOffset = OUT_W'(lagAccum >>> ALIGN);
  assign carrierLeadFreq = lead;
  assign loopState = state;
endmodule

// File: tb/tb_carrier_track_loop.sv
// tb_carrier_track_loop: directed and randomized checks of carrier_track_loop against an integer reference model
module tb_carrier_track_loop;
  localparam int ERR_W = 8;
  localparam int ACC_W = 40;
  localparam int OUT_W = 32;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic reset, sync, errorEn, invertError, zeroError, sweepEnable, clearAccum;
  logic [ERR_W-1:0] error;
  logic [4:0] acqLeadExp, acqLagExp, trkLeadExp, trkLagExp;
  logic [OUT_W-1:0] limit, sweepRate;
  logic [ERR_W-2:0] syncThreshold;
  logic [CNT_W-2:0] lockCount;
  logic [ERR_W-1:0] loopError;
  logic [OUT_W-1:0] carrierFreqOffset, carrierLeadFreq;
  logic carrierFreqEn, carrierLock;
  logic signed [CNT_W-1:0] lockCounter;
  logic [1:0] loopState;
  int nChecks = 0;
  int nFails = 0;
  int mErr, mCnt, mState, mDir;
  longint mLead, mAcc;
  bit mLock, mEn;

  carrier_track_loop #(.ERR_W(ERR_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sync(sync), .errorEn(errorEn), .error(error),
    .invertError(invertError), .zeroError(zeroError), .sweepEnable(sweepEnable),
    .clearAccum(clearAccum), .acqLeadExp(acqLeadExp), .acqLagExp(acqLagExp),
    .trkLeadExp(trkLeadExp), .trkLagExp(trkLagExp), .limit(limit), .sweepRate(sweepRate),
    .syncThreshold(syncThreshold), .lockCount(lockCount), .loopError(loopError),
    .carrierFreqOffset(carrierFreqOffset), .carrierLeadFreq(carrierLeadFreq),
    .carrierFreqEn(carrierFreqEn), .carrierLock(carrierLock), .lockCounter(lockCounter),
    .loopState(loopState)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gainOf(input logic [4:0] e);
    return (int'(e) > ACC_W - ERR_W) ? ACC_W - ERR_W : int'(e);
  endfunction

  // reference: states 0 sweep, 1 acquire, 2 track; mDir +1/-1 sweep direction
  task automatic modelClock();
    int e, mag, lc, adj;
    longint lim, stp, sum;
    bit v, inTh, lockEv, unlockEv, reach;
    int ns;
    if (reset) begin
      mErr = 0; mLead = 0; mAcc = 0; mCnt = 0; mLock = 0; mEn = 0; mDir = 1;
      mState = sweepEnable ? 0 : 1;
      return;
    end
    v = sync && errorEn;
    e = int'($signed(error));
    mag = e < 0 ? -e : e;
    inTh = mag <= int'(syncThreshold);
    lc = int'(lockCount);
    lim = longint'(limit) * (longint'(1) << (ACC_W - OUT_W));
    stp = longint'(sweepRate) * (longint'(1) << (ACC_W - OUT_W));
    lockEv = v && inTh && mCnt == lc;
    unlockEv = v && !inTh && mCnt == -lc;
    reach = v && !inTh && (mCnt == -lc || mCnt - 1 == -lc);
    ns = mState;
    if (mState == 0 && (!sweepEnable || (v && inTh))) ns = 1;
    if (mState == 1 && lockEv) ns = 2;
    else if (mState == 1 && sweepEnable && reach) ns = 0;
    if (mState == 2 && unlockEv) ns = sweepEnable ? 0 : 1;
    mEn = v;
    if (v) begin
      adj = (zeroError || mState == 0) ? 0 : !invertError ? e : (e == -128) ? 127 : -e;
      mLead = longint'(mErr) * (longint'(1) << gainOf(mState == 2 ? trkLeadExp : acqLeadExp));
      if (!clearAccum) begin
        if (mState == 0) begin
          sum = mAcc + longint'(mDir) * stp;
          if (mDir > 0 && sum >= lim) begin sum = lim; mDir = -1; end
          else if (mDir < 0 && sum <= -lim) begin sum = -lim; mDir = 1; end
        end else begin
          sum = mAcc + longint'(mErr) * (longint'(1) << gainOf(mState == 2 ? trkLagExp : acqLagExp));
          if (sum > lim) sum = lim;
          if (sum < -lim) sum = -lim;
        end
        mAcc = sum;
      end
      mErr = adj;
      if (lockEv) begin mLock = 1; mCnt = 0; end
      else if (unlockEv) begin mLock = 0; mCnt = 0; end
      else mCnt = inTh ? mCnt + 1 : mCnt - 1;
    end
    if (clearAccum) begin mAcc = 0; mDir = 1; end
    mState = ns;
  endtask

  task automatic compareAll();
    checkValue("loopError", 64'(loopError), 64'(mErr) & 64'hFF);
    checkValue("freqOffset", 64'(carrierFreqOffset), 64'(mAcc >>> (ACC_W - OUT_W)) & 64'hFFFF_FFFF);
    checkValue("leadFreq", 64'(carrierLeadFreq), 64'(mLead >>> (ACC_W - OUT_W)) & 64'hFFFF_FFFF);
    checkValue("freqEn", 64'(carrierFreqEn), 64'(mEn));
    checkValue("lock", 64'(carrierLock), 64'(mLock));
    checkValue("lockCounter", 64'(lockCounter) & 64'hFFFF, 64'(mCnt) & 64'hFFFF);
    checkValue("loopState", 64'(loopState), 64'(mState));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      modelClock();
      @(posedge clk);
      #1;
      compareAll();
    end
  endtask

  task automatic doReset(input logic sw);
    sweepEnable = sw;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    {reset, sync, errorEn, invertError, zeroError, sweepEnable, clearAccum} = '0;
    error = '0;
    {acqLeadExp, acqLagExp, trkLeadExp, trkLagExp} = '0;
    limit = 32'h7FFF_FFFF;
    sweepRate = '0;
    syncThreshold = '0;
    lockCount = 15'd100;
    mErr = 0; mCnt = 0; mState = 0; mDir = 1; mLead = 0; mAcc = 0; mLock = 0; mEn = 0;
    doReset(1'b0);
    checkValue("rstState", 64'(loopState), 64'd1);
    sync = 1'b1; errorEn = 1'b1; acqLagExp = 5'd8; acqLeadExp = 5'd4; error = 8'h10;
    tick(3);
    checkValue("lagStep", 64'(carrierFreqOffset), 64'h20);
    invertError = 1'b1; error = 8'h80;
    tick();
    checkValue("invertMin", 64'(loopError), 64'h7F);
    zeroError = 1'b1;
    tick();
    checkValue("zeroErr", 64'(loopError), 64'h00);
    invertError = 1'b0; zeroError = 1'b0;
    doReset(1'b0);
    limit = 32'h100; acqLagExp = 5'd24; error = 8'h7F;
    tick(2);
    checkValue("satPos", 64'(carrierFreqOffset), 64'h100);
    error = 8'h80;
    tick(3);
    checkValue("satNeg", 64'(carrierFreqOffset), 64'hFFFF_FF00);
    doReset(1'b0);
    limit = 32'h7FFF_FFFF; acqLagExp = 5'd6; trkLagExp = 5'd2; trkLeadExp = 5'd1;
    lockCount = 15'd3; syncThreshold = 7'd4; error = 8'd2;
    tick(3);
    checkValue("noLockYet", 64'(carrierLock), 64'd0);
    tick();
    checkValue("lockRise", 64'(carrierLock), 64'd1);
    checkValue("trackState", 64'(loopState), 64'd2);
    tick(2);
    reset = 1'b1; clearAccum = 1'b1;
    tick();
    checkValue("rstLock", 64'(carrierLock), 64'd0);
    checkValue("rstOffset", 64'(carrierFreqOffset), 64'd0);
    reset = 1'b0; clearAccum = 1'b0;
    doReset(1'b1);
    checkValue("rstSweep", 64'(loopState), 64'd0);
    sweepRate = 32'h40; limit = 32'h100; error = 8'h50;
    tick(4);
    checkValue("sweepTop", 64'(carrierFreqOffset), 64'h100);
    tick();
    checkValue("sweepBack", 64'(carrierFreqOffset), 64'hC0);
    error = 8'h00;
    tick();
    checkValue("sweepAcq", 64'(loopState), 64'd1);
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        lockCount = 15'($urandom_range(0, 4));
        sweepEnable = 1'($urandom_range(0, 1));
      end
      reset = (i % 500 == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 150) == 0) sweepEnable = ~sweepEnable;
      sync = $urandom_range(0, 3) != 0;
      errorEn = $urandom_range(0, 7) != 0;
      error = $urandom_range(0, 1) ? 8'($urandom_range(0, 8) - 4) : 8'($urandom);
      invertError = $urandom_range(0, 9) == 0;
      zeroError = $urandom_range(0, 19) == 0;
      clearAccum = $urandom_range(0, 49) == 0;
      syncThreshold = 7'($urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0) begin
        acqLeadExp = 5'($urandom); trkLeadExp = 5'($urandom);
        acqLagExp = 5'($urandom_range(0, 26)); trkLagExp = 5'($urandom_range(0, 26));
        limit = $urandom & 32'h7FFF_FFFF;
        sweepRate = $urandom_range(0, 1) ? 32'($urandom_range(1, 4096)) : ($urandom & 32'h0FFF_FFFF);
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
